alu_mc: RTL
===========

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits (legal range 8..64).
REQ-002 Parameter: SHW, default 5, shift-amount width; SHALL equal clog2(WIDTH).
REQ-003 Port: clk  input  1  sole clock; all state changes on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: start  input  1  operation request; sampled only when busy=0.
REQ-006 Port: sel  input  4  opcode: 0 add, 1 sub, 2 and, 3 or, 4 sltu, 5 slt, 6 xor, 7 nor, 8 sll, 9 srl, 10 sra, 11 mul, 12 divu, 13 remu; 14-15 illegal.
REQ-007 Port: EA  input  WIDTH  operand A.
REQ-008 Port: EB  input  WIDTH  operand B; for shifts, EB[SHW-1:0] is the shift amount.
REQ-009 Port: res  output  WIDTH  registered result, held until next completion.
REQ-010 Port: flag  output  1  registered zero flag, 1 iff res==0, updated together with res.
REQ-011 Port: ovf  output  1  registered signed overflow for add/sub; 0 for all other ops.
REQ-012 Port: dz  output  1  registered divide-by-zero indication for divu/remu; 0 otherwise.
REQ-013 Port: busy  output  1  high while a multi-cycle op is in progress.
REQ-014 Port: done  output  1  one-cycle pulse marking res/flag/ovf/dz valid.

Function
REQ-015 FSM states SHALL be IDLE, RUN, DONE; reset state IDLE.
REQ-016 IDLE, start=1, sel in 0-10: SHALL compute result, register it, go to DONE; done=1 in the next cycle (latency 1).
REQ-017 IDLE, start=1, sel 11-13 with EB!=0: SHALL latch EA, EB, sel, load count=WIDTH, go to RUN, busy=1 from the next cycle.
REQ-018 RUN: one iteration per cycle (mul: shift-add on latched operands; divu/remu: restoring divide, one quotient bit per cycle); count decrements; at count==1 the final value SHALL be registered and FSM SHALL go to DONE.
REQ-019 Multi-cycle latency: done SHALL pulse exactly WIDTH+1 cycles after the start sample; busy high for exactly WIDTH cycles.
REQ-020 DONE: done=1 for exactly one cycle, then IDLE; start in DONE SHALL be ignored.
REQ-021 start while busy=1 SHALL be ignored; EA/EB/sel changes during RUN SHALL NOT affect the result.
REQ-022 add/sub SHALL wrap modulo 2^WIDTH; ovf=1 iff operand signs produce an opposite-sign result (add: same signs; sub: differing signs).
REQ-023 sltu: res=1 iff EA<EB unsigned; slt: res=1 iff EA<EB signed; otherwise 0, zero-extended.
REQ-024 sll/srl/sra SHALL use only EB[SHW-1:0]; sra SHALL replicate EA[WIDTH-1].
REQ-025 mul SHALL return low WIDTH bits of the unsigned product.
REQ-026 divu/remu with EB==0: SHALL complete with latency 1, res=all ones (divu) or EA (remu), dz=1, no RUN entry.
REQ-027 Illegal sel (14-15): SHALL complete with latency 1, res=0, flag=1, ovf=0, dz=0.
REQ-028 flag SHALL be computed from the newly registered result value, never the previous one.
REQ-029 res/flag/ovf/dz SHALL change only in the cycle done rises.

Reset
REQ-030 rst_n=0 SHALL immediately force FSM=IDLE, res=0, flag=1, ovf=0, dz=0, busy=0, done=0, count=0.
REQ-031 Reset during RUN SHALL abort the op; no done pulse SHALL follow deassertion.
REQ-032 First start SHALL be accepted on the first rising edge with rst_n=1.

Verification
REQ-033 add 0x7FFFFFFF+0x00000001 -> after 1 cycle done=1, res=0x80000000, ovf=1, flag=0.
REQ-034 sub 0x5-0x5 then slt 0xFFFFFFFF,0x1 -> res=0/flag=1, then res=1 (sltu same operands -> 0).
REQ-035 mul 0x0001_0003*0x0000_0010 -> busy 32 cycles, done at cycle 33, res=0x0010_0030; start pulses during busy ignored.
REQ-036 divu 100/7 -> res=14; remu 100/7 -> res=2; divu 5/0 -> 1 cycle, res=0xFFFFFFFF, dz=1.
REQ-037 sra 0x80000000 by EB=0x24 -> uses amount 4, res=0xF8000000.
REQ-038 Assert rst_n=0 at cycle 10 of a divu -> outputs at reset values immediately; no done pulse; next add completes normally.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops, iterative shift-add multiply
// and restoring divide/remainder sequenced by an IDLE/RUN/DONE controller.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       sel,
    input  logic [WIDTH-1:0] EA,
    input  logic [WIDTH-1:0] EB,
    output logic [WIDTH-1:0] res,
    output logic             flag,
    output logic             ovf,
    output logic             dz,
    output logic             busy,
    output logic             done
);
    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_NOR  = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;
    localparam logic [3:0] OP_DIVU = 4'd12;
    localparam logic [3:0] OP_REMU = 4'd13;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             flag_q, flag_d;
    logic             ovf_q, ovf_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0] sum, diff;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] imm_res;
    logic             imm_ovf, imm_dz;
    logic             go_multi;

    // Single-cycle result path, evaluated directly on the live operands.
    always_comb begin
        sum      = EA + EB;
        diff     = EA - EB;
        shamt    = EB[SHW-1:0];
        imm_res  = '0;
        imm_ovf  = 1'b0;
        imm_dz   = 1'b0;
        go_multi = ((sel == OP_MUL) || (sel == OP_DIVU) || (sel == OP_REMU)) && (EB != '0);
        case (sel)
            OP_ADD: begin
                imm_res = sum;
                imm_ovf = (EA[WIDTH-1] == EB[WIDTH-1]) && (sum[WIDTH-1] != EA[WIDTH-1]);
            end
            OP_SUB: begin
                imm_res = diff;
                imm_ovf = (EA[WIDTH-1] != EB[WIDTH-1]) && (diff[WIDTH-1] != EA[WIDTH-1]);
            end
            OP_AND:  imm_res = EA & EB;
            OP_OR:   imm_res = EA | EB;
            OP_SLTU: imm_res = {{(WIDTH-1){1'b0}}, (EA < EB)};
            OP_SLT:  imm_res = {{(WIDTH-1){1'b0}}, ($signed(EA) < $signed(EB))};
            OP_XOR:  imm_res = EA ^ EB;
            OP_NOR:  imm_res = ~(EA | EB);
            OP_SLL:  imm_res = EA << shamt;
            OP_SRL:  imm_res = EA >> shamt;
            OP_SRA:  imm_res = $signed(EA) >>> shamt;
            OP_MUL:  imm_res = '0;
            OP_DIVU: begin
                imm_res = '1;
                imm_dz  = 1'b1;
            end
            OP_REMU: begin
                imm_res = EA;
                imm_dz  = 1'b1;
            end
            default: imm_res = '0;
        endcase
    end

    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH:0]   rem_shift;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_diff, rem_next, quo_next;

    // One iteration of each sequential algorithm; a_q doubles as the dividend/quotient shifter.
    always_comb begin
        mul_acc   = acc_q + (b_q[0] ? a_q : '0);
        rem_shift = {acc_q, a_q[WIDTH-1]};
        rem_ge    = rem_shift >= {1'b0, b_q};
        rem_diff  = rem_shift[WIDTH-1:0] - b_q;
        rem_next  = rem_ge ? rem_diff : rem_shift[WIDTH-1:0];
        quo_next  = {a_q[WIDTH-2:0], rem_ge};
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (go_multi) begin
                        op_d    = sel;
                        a_d     = EA;
                        b_d     = EB;
                        acc_d   = '0;
                        count_d = CNT_LOAD;
                        state_d = RUN;
                    end else begin
                        res_d   = imm_res;
                        ovf_d   = imm_ovf;
                        dz_d    = imm_dz;
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                count_d = count_q - 1'b1;
                if (op_q == OP_MUL) begin
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                    acc_d = mul_acc;
                end else begin
                    a_d   = quo_next;
                    acc_d = rem_next;
                end
                if (count_q == 1) begin
                    if (op_q == OP_MUL)       res_d = mul_acc;
                    else if (op_q == OP_DIVU) res_d = quo_next;
                    else                      res_d = rem_next;
                    ovf_d   = 1'b0;
                    dz_d    = 1'b0;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // res_d equals res_q outside completion, so flag tracks the value being registered.
        flag_d = (res_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            flag_q  <= 1'b1;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            flag_q  <= flag_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
        end
    end

    assign res  = res_q;
    assign flag = flag_q;
    assign ovf  = ovf_q;
    assign dz   = dz_q;
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
endmodule
